// File: rtl/gpio_apb_arbiter.sv
// Two-requester round-robin arbiter driving a single APB master port.
// Optional ACCESS-phase timeout abort enabled by defining ARB_TIMEOUT_EN.
module gpio_apb_arbiter #(
  parameter int unsigned ADDR_W  = 33,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [31:0]       wdata0,
  output logic              done0,
  output logic [31:0]       rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata1,
  output logic              done1,
  output logic [31:0]       rdata1,
  output logic              err1,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [31:0]       PWDATA,
  input  logic [31:0]       PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output logic              busy,
  output logic              gnt
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t            r_state, w_next;
  logic              r_gnt;
  logic              w_grant, w_grant_port, w_abort, w_finish;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [31:0]       r_pwdata;
  logic [31:0]       r_rdata0, r_rdata1;
  logic              r_err0, r_err1;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] r_tcnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                       r_tcnt <= '0;
    else if (r_state == SETUP)          r_tcnt <= '0;
    else if (r_state == ACCESS && !PREADY) r_tcnt <= r_tcnt + 1'b1;
  end

  assign w_abort = (r_state == ACCESS) && !PREADY && (r_tcnt == TW'(TIMEOUT - 1));
`else
  // TIMEOUT only sizes the abort counter; reference it so the default build stays warning-free.
  if (TIMEOUT == 0) begin : g_timeout_unused
  end
  assign w_abort = 1'b0;
`endif

  assign w_finish = (r_state == ACCESS) && (PREADY || w_abort);

  always_comb begin
    w_next       = r_state;
    w_grant      = 1'b0;
    w_grant_port = r_gnt;
    unique case (r_state)
      IDLE: if (req0 || req1) begin
        w_grant      = 1'b1;
        // On a tie, the port that was not granted last wins.
        w_grant_port = (req0 && req1) ? ~r_gnt : req1;
        w_next       = SETUP;
      end
      SETUP:   w_next = ACCESS;
      ACCESS:  if (w_finish) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state  <= IDLE;
      r_gnt    <= 1'b1;
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_gnt    <= w_grant_port;
        r_pwrite <= w_grant_port ? we1    : we0;
        r_paddr  <= w_grant_port ? addr1  : addr0;
        r_pwdata <= w_grant_port ? wdata1 : wdata0;
      end
      if (w_finish) begin
        if (!r_gnt) begin
          if (w_abort)        r_rdata0 <= '0;
          else if (!r_pwrite) r_rdata0 <= PRDATA;
          r_err0 <= w_abort | PSLVERR;
        end else begin
          if (w_abort)        r_rdata1 <= '0;
          else if (!r_pwrite) r_rdata1 <= PRDATA;
          r_err1 <= w_abort | PSLVERR;
        end
      end
    end
  end

  assign PSEL    = (r_state == SETUP) || (r_state == ACCESS);
  assign PENABLE = (r_state == ACCESS);
  assign PWRITE  = r_pwrite;
  assign PADDR   = r_paddr;
  assign PWDATA  = r_pwdata;
  assign busy    = (r_state != IDLE);
  assign gnt     = r_gnt;
  assign done0   = (r_state == DONE) && !r_gnt;
  assign done1   = (r_state == DONE) && r_gnt;
  assign rdata0  = r_rdata0;
  assign rdata1  = r_rdata1;
  assign err0    = r_err0;
  assign err1    = r_err1;

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// Bench for gpio_apb_arbiter: directed literal scenarios, then random traffic
// compared every cycle against a transaction-level model.
module tb_gpio_apb_arbiter;

  localparam int unsigned AW = 33;
  localparam int unsigned TO = 16;

  logic          PCLK, PRESETn;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [31:0]   wdata0, wdata1;
  logic          done0, err0, done1, err1;
  logic [31:0]   rdata0, rdata1;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR, busy, gnt;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA, PRDATA;

  int n_chk  = 0;
  int n_pass = 0;

  gpio_apb_arbiter #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .done0(done0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .done1(done1), .rdata1(rdata1), .err1(err1),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .busy(busy), .gnt(gnt)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step;
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  // Transaction-level model: age = edges since grant, fin = completion sampled.
  int            m_age;
  bit            m_fin, m_port, m_last;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wd;
  logic [31:0]   m_rd  [2];
  bit            m_err [2];

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      m_age = 0; m_fin = 0; m_last = 1;
      m_rd[0] = 0; m_rd[1] = 0; m_err[0] = 0; m_err[1] = 0;
    end else if (m_fin) begin
      m_age = 0; m_fin = 0;
    end else if (m_age == 0) begin
      if (req0 || req1) begin
        m_port = (req0 && req1) ? !m_last : req1;
        m_last = m_port;
        m_we   = m_port ? we1 : we0;
        m_addr = m_port ? addr1 : addr0;
        m_wd   = m_port ? wdata1 : wdata0;
        m_age  = 1;
      end
    end else begin
      if (m_age >= 2) begin
        if (PREADY) begin
          if (!m_we) m_rd[m_port] = PRDATA;
          m_err[m_port] = PSLVERR;
          m_fin = 1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (m_age - 1 == TO) begin
          m_rd[m_port] = 0; m_err[m_port] = 1; m_fin = 1;
        end
`endif
      end
      m_age++;
    end
  end

  always @(negedge PCLK) begin
    if (PRESETn) begin
      chk("cmp_psel",    PSEL,    m_age > 0 && !m_fin);
      chk("cmp_penable", PENABLE, m_age >= 2 && !m_fin);
      chk("cmp_busy",    busy,    m_age > 0);
      chk("cmp_gnt",     gnt,     m_last);
      chk("cmp_done0",   done0,   m_fin && m_port == 0);
      chk("cmp_done1",   done1,   m_fin && m_port == 1);
      chk("cmp_rdata0",  rdata0,  m_rd[0]);
      chk("cmp_rdata1",  rdata1,  m_rd[1]);
      chk("cmp_err0",    err0,    m_err[0]);
      chk("cmp_err1",    err1,    m_err[1]);
      if (m_age > 0) begin
        chk("cmp_pwrite", PWRITE, m_we);
        chk("cmp_paddr",  PADDR,  m_addr);
        chk("cmp_pwdata", PWDATA, m_wd);
      end
    end
  end

  initial begin
    int k, nd;
    bit order [3];
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    PRDATA = '0; PREADY = 0; PSLVERR = 0;
    PRESETn = 0;
    repeat (3) @(negedge PCLK);

    chk("rst_psel", PSEL, 0);     chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0); chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0); chk("rst_done", {done0, done1}, 0);
    chk("rst_err", {err0, err1}, 0);
    chk("rst_rdata", {rdata0, rdata1}, 0);
    chk("rst_busy", busy, 0);     chk("rst_gnt", gnt, 1);

    // Zero-wait write on port 0.
    #2 PRESETn = 1;
    req0 = 1; we0 = 1; addr0 = '0; wdata0 = '0; PREADY = 1;
    step; chk("w0_psel", PSEL, 1); chk("w0_pen_setup", PENABLE, 0);
    step; chk("w0_pen", PENABLE, 1); chk("w0_paddr", PADDR, 0); chk("w0_pwdata", PWDATA, 0);
    step; chk("w0_done", done0, 1); chk("w0_psel_done", PSEL, 0);
    req0 = 0;
    step; chk("w0_idle", busy, 0);

    // Read on port 1 with three wait cycles.
    req1 = 1; we1 = 0; addr1 = AW'(1); PRDATA = 32'hFFFF_FFFF; PREADY = 0;
    repeat (5) step;
    chk("r1_waiting", PENABLE, 1); chk("r1_nodone", done1, 0);
    PREADY = 1;
    step; chk("r1_done", done1, 1); chk("r1_rdata", rdata1, 32'hFFFF_FFFF); chk("r1_err", err1, 0);
    req1 = 0;
    step;

    // Write with slave error; requester inputs change after grant.
    req0 = 1; we0 = 1; addr0 = AW'(2); wdata0 = 32'd9; PSLVERR = 1; PREADY = 1;
    step; addr0 = AW'(7); wdata0 = 32'h55; we0 = 0;
    step; chk("e0_paddr", PADDR, 2); chk("e0_pwdata", PWDATA, 9); chk("e0_pwrite", PWRITE, 1);
    step; chk("e0_done", done0, 1); chk("e0_err", err0, 1); chk("e0_rdata", rdata0, 0);
    chk("e0_rdata1_kept", rdata1, 32'hFFFF_FFFF); chk("e0_err1_kept", err1, 0);
    req0 = 0; PSLVERR = 0;
    step;

    // Reset during ACCESS.
    req1 = 1; we1 = 0; addr1 = AW'(5); PREADY = 0;
    step; step;
    chk("ra_in_access", PENABLE, 1);
    #3 PRESETn = 0; req1 = 0;
    #1 chk("ra_psel", PSEL, 0); chk("ra_penable", PENABLE, 0);
    chk("ra_done", done1, 0); chk("ra_busy", busy, 0); chk("ra_rdata1", rdata1, 0);
    @(negedge PCLK); #2 PRESETn = 1;
    repeat (3) begin step; chk("ra_nodone", {done0, done1}, 0); end

    // Both requesting from reset: grants alternate 0,1,0.
    PRESETn = 0; #1; PRESETn = 1;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; PRDATA = 32'hA5A5_0001; PREADY = 1;
    nd = 0;
    for (int i = 0; i < 40 && nd < 3; i++) begin
      step;
      if (done0 || done1) begin order[nd] = done1; nd++; end
      if (nd == 3) begin req0 = 0; req1 = 0; end
    end
    chk("rr_count", nd, 3);
    chk("rr_first", order[0], 0); chk("rr_second", order[1], 1); chk("rr_third", order[2], 0);
    step;

`ifdef ARB_TIMEOUT_EN
    req0 = 1; we0 = 0; PREADY = 0;
    k = 0;
    for (int i = 0; i < 60; i++) begin
      step; k++;
      if (done0) break;
    end
    chk("to_cycles", k, TO + 2); chk("to_done", done0, 1);
    chk("to_err", err0, 1); chk("to_rdata", rdata0, 0);
    req0 = 0;
    step;
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step;
      if (req0 && m_fin && m_port == 0) req0 = 0;
      else if (!req0 && $urandom_range(0, 2) == 0) req0 = 1;
      if (req1 && m_fin && m_port == 1) req1 = 0;
      else if (!req1 && $urandom_range(0, 2) == 0) req1 = 1;
      we0 = 1'($urandom); addr0 = AW'({$urandom, $urandom}); wdata0 = $urandom;
      we1 = 1'($urandom); addr1 = AW'({$urandom, $urandom}); wdata1 = $urandom;
      PREADY  = ($urandom_range(0, 2) != 0);
      PRDATA  = $urandom;
      PSLVERR = ($urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
